// File: rtl/pipeline_ctrl_if.sv
// Handshake bundle between the datapath and the stall/flush controller:
// decode/EX hazard fields and the memory handshake in, per-stage control out.
interface pipeline_ctrl_if #(
  parameter int REG_W = 4
);
  logic [REG_W-1:0] id_rs;
  logic [REG_W-1:0] id_rt;
  logic             id_uses_rs;
  logic             id_uses_rt;
  logic             id_halt;
  logic             branch_taken;
  logic             ex_memread;
  logic [REG_W-1:0] ex_rd;
  logic             dmem_req;
  logic             dmem_ack;
  logic             pc_we;
  logic             if_id_we;
  logic             if_id_flush;
  logic             id_ex_flush;
  logic             pipe_we;
  logic             halted;
  logic [15:0]      stall_cycles;

  modport master (
    output id_rs, id_rt, id_uses_rs, id_uses_rt, id_halt, branch_taken,
           ex_memread, ex_rd, dmem_req, dmem_ack,
    input  pc_we, if_id_we, if_id_flush, id_ex_flush, pipe_we, halted, stall_cycles
  );

  modport slave (
    input  id_rs, id_rt, id_uses_rs, id_uses_rt, id_halt, branch_taken,
           ex_memread, ex_rd, dmem_req, dmem_ack,
    output pc_we, if_id_we, if_id_flush, id_ex_flush, pipe_we, halted, stall_cycles
  );
endinterface

// File: rtl/pipeline_ctrl.sv
// Central stall/flush controller for the 5-stage pipeline: load-use stalls,
// branch flushes, data-memory waits, HLT drain and a saturating stall counter.
module pipeline_ctrl #(
  parameter int DRAIN_CYCLES = 3,
  parameter int REG_W        = 4
) (
  input  logic            clk,
  input  logic            rst,
  pipeline_ctrl_if.slave  bus
);
  localparam int CNT_W = $clog2(DRAIN_CYCLES + 1);

  typedef enum logic [1:0] {RUN, MEM_WAIT, DRAIN, HALTED} state_t;

  state_t             state_r, state_nxt_s;
  logic [CNT_W-1:0]   drain_cnt_r, drain_cnt_nxt_s;
  logic [15:0]        stall_cnt_r;
  logic               lu_s, mw_s;
  logic               pc_we_s, if_id_we_s, if_id_flush_s, id_ex_flush_s, pipe_we_s, halted_s;

  // Hazard detection: load-use against the load in EX, and an outstanding data-memory miss
  always_comb begin
    lu_s = bus.ex_memread && (bus.ex_rd != {REG_W{1'b0}}) &&
           ((bus.id_uses_rs && (bus.id_rs == bus.ex_rd)) ||
            (bus.id_uses_rt && (bus.id_rt == bus.ex_rd)));
    mw_s = bus.dmem_req && !bus.dmem_ack;
  end

  // Next-state and per-stage control decode
  always_comb begin
    state_nxt_s     = state_r;
    drain_cnt_nxt_s = drain_cnt_r;
    pc_we_s         = 1'b0;
    if_id_we_s      = 1'b0;
    if_id_flush_s   = 1'b0;
    id_ex_flush_s   = 1'b0;
    pipe_we_s       = 1'b0;
    halted_s        = 1'b0;
    case (state_r)
      RUN, MEM_WAIT: begin
        // MEM_WAIT freezes until ack, then decodes exactly as RUN with the miss cleared
        if ((state_r == RUN) && mw_s) begin
          state_nxt_s = MEM_WAIT;
        end else if ((state_r == MEM_WAIT) && !bus.dmem_ack) begin
          state_nxt_s = MEM_WAIT;
        end else if (lu_s) begin
          state_nxt_s   = RUN;
          id_ex_flush_s = 1'b1;
          pipe_we_s     = 1'b1;
        end else if (bus.branch_taken) begin
          state_nxt_s   = RUN;
          pc_we_s       = 1'b1;
          if_id_we_s    = 1'b1;
          if_id_flush_s = 1'b1;
          pipe_we_s     = 1'b1;
        end else if (bus.id_halt) begin
          state_nxt_s     = DRAIN;
          drain_cnt_nxt_s = CNT_W'(DRAIN_CYCLES - 1);
          if_id_we_s      = 1'b1;
          if_id_flush_s   = 1'b1;
          pipe_we_s       = 1'b1;
        end else begin
          state_nxt_s = RUN;
          pc_we_s     = 1'b1;
          if_id_we_s  = 1'b1;
          pipe_we_s   = 1'b1;
        end
      end
      DRAIN: begin
        if_id_we_s    = 1'b1;
        if_id_flush_s = 1'b1;
        id_ex_flush_s = 1'b1;
        if (mw_s) begin
          pipe_we_s = 1'b0;
        end else if (drain_cnt_r == {CNT_W{1'b0}}) begin
          pipe_we_s   = 1'b1;
          state_nxt_s = HALTED;
        end else begin
          pipe_we_s       = 1'b1;
          drain_cnt_nxt_s = drain_cnt_r - CNT_W'(1);
        end
      end
      HALTED: begin
        halted_s = 1'b1;
      end
      default: begin
        state_nxt_s     = RUN;
        drain_cnt_nxt_s = {CNT_W{1'b0}};
      end
    endcase
  end

  // State and drain counter registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= RUN;
      drain_cnt_r <= {CNT_W{1'b0}};
    end else begin
      state_r     <= state_nxt_s;
      drain_cnt_r <= drain_cnt_nxt_s;
    end
  end

  // Saturating count of PC-stalled cycles, frozen once halted
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_r <= 16'd0;
    end else if (!pc_we_s && (state_r != HALTED) && (stall_cnt_r != 16'hFFFF)) begin
      stall_cnt_r <= stall_cnt_r + 16'd1;
    end else begin
      stall_cnt_r <= stall_cnt_r;
    end
  end

  assign bus.pc_we        = pc_we_s;
  assign bus.if_id_we     = if_id_we_s;
  assign bus.if_id_flush  = if_id_flush_s;
  assign bus.id_ex_flush  = id_ex_flush_s;
  assign bus.pipe_we      = pipe_we_s;
  assign bus.halted       = halted_s;
  assign bus.stall_cycles = stall_cnt_r;
endmodule

// File: tb/tb_pipeline_ctrl.sv
// Scoreboard bench for pipeline_ctrl: directed per-cycle vectors push expected
// control words; a negedge monitor pops and compares them against the DUT.
module tb_pipeline_ctrl;
  logic clk;
  logic rst;

  pipeline_ctrl_if #(.REG_W(4)) bus ();

  pipeline_ctrl #(.DRAIN_CYCLES(3), .REG_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [5:0]  ctl;   // {pc_we, if_id_we, if_id_flush, id_ex_flush, pipe_we, halted}
    logic [15:0] stall;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  localparam logic [5:0] E_RUN   = 6'b110010;
  localparam logic [5:0] E_LU    = 6'b000110;
  localparam logic [5:0] E_BR    = 6'b111010;
  localparam logic [5:0] E_HLT   = 6'b011010;
  localparam logic [5:0] E_FRZ   = 6'b000000;
  localparam logic [5:0] E_DRN   = 6'b011110;
  localparam logic [5:0] E_DRNM  = 6'b011100;
  localparam logic [5:0] E_HALTD = 6'b000001;

  // Monitor: outputs are combinational, so each cycle with a pushed entry is compared at negedge
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t       e;
      logic [5:0] got;
      e   = sb.pop_front();
      got = {bus.pc_we, bus.if_id_we, bus.if_id_flush, bus.id_ex_flush, bus.pipe_we, bus.halted};
      checks++;
      if (got !== e.ctl || bus.stall_cycles !== e.stall) begin
        errors++;
        $display("FAIL %s: ctl=%b stall=%0d, required ctl=%b stall=%0d",
                 e.name, got, bus.stall_cycles, e.ctl, e.stall);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input string nm, input logic [5:0] c, input logic [15:0] s);
    exp_t e;
    e.name  = nm;
    e.ctl   = c;
    e.stall = s;
    sb.push_back(e);
  endtask

  task automatic idle();
    bus.id_rs        = 4'd0;
    bus.id_rt        = 4'd0;
    bus.id_uses_rs   = 1'b0;
    bus.id_uses_rt   = 1'b0;
    bus.id_halt      = 1'b0;
    bus.branch_taken = 1'b0;
    bus.ex_memread   = 1'b0;
    bus.ex_rd        = 4'd0;
    bus.dmem_req     = 1'b0;
    bus.dmem_ack     = 1'b0;
  endtask

  task automatic set_lu(input logic [3:0] rd);
    bus.ex_memread = 1'b1;
    bus.ex_rd      = rd;
    bus.id_rs      = 4'd5;
    bus.id_uses_rs = 1'b1;
  endtask

  initial begin
    rst = 1'b1;
    idle();
    tick(); expect_out("reset_held", E_RUN, 16'd0);
    tick(); rst = 1'b0; expect_out("reset_idle", E_RUN, 16'd0);

    // Load-use on rs, then an x0 destination and an unused-source match that must not stall
    tick(); set_lu(4'd5); expect_out("lu_rs", E_LU, 16'd0);
    tick(); idle(); expect_out("lu_after", E_RUN, 16'd1);
    tick(); set_lu(4'd0); expect_out("lu_rd0", E_RUN, 16'd1);
    tick(); set_lu(4'd5); bus.id_uses_rs = 1'b0; expect_out("lu_unused", E_RUN, 16'd1);
    tick(); idle(); bus.ex_memread = 1'b1; bus.ex_rd = 4'd7; bus.id_rt = 4'd7; bus.id_uses_rt = 1'b1;
    expect_out("lu_rt", E_LU, 16'd1);

    // Load-use beats branch; branch is taken on the following cycle
    tick(); idle(); set_lu(4'd5); bus.branch_taken = 1'b1; expect_out("lu_br", E_LU, 16'd2);
    tick(); idle(); bus.branch_taken = 1'b1; expect_out("br", E_BR, 16'd3);
    tick(); idle(); expect_out("br_after", E_RUN, 16'd3);

    // Miss acked 4 cycles after the request; load-use ignored while waiting; branch decoded on ack
    tick(); bus.dmem_req = 1'b1; expect_out("miss0", E_FRZ, 16'd3);
    tick(); expect_out("miss1", E_FRZ, 16'd4);
    tick(); set_lu(4'd5); expect_out("miss2_lu", E_FRZ, 16'd5);
    tick(); idle(); bus.dmem_req = 1'b1; expect_out("miss3", E_FRZ, 16'd6);
    tick(); bus.dmem_ack = 1'b1; bus.branch_taken = 1'b1; expect_out("miss_ack_br", E_BR, 16'd7);
    tick(); idle(); expect_out("miss_after", E_RUN, 16'd7);

    // HLT at t: halted from t+4, counter frozen once halted
    tick(); bus.id_halt = 1'b1; expect_out("hlt_t0", E_HLT, 16'd7);
    tick(); idle(); expect_out("drain_t1", E_DRN, 16'd8);
    tick(); expect_out("drain_t2", E_DRN, 16'd9);
    tick(); expect_out("drain_t3", E_DRN, 16'd10);
    tick(); bus.branch_taken = 1'b1; expect_out("halted_t4", E_HALTD, 16'd11);
    tick(); idle(); expect_out("halted_t5", E_HALTD, 16'd11);

    // Reset out of HALTED, then asynchronous reset in the middle of DRAIN
    tick(); rst = 1'b1; expect_out("rst_halted", E_RUN, 16'd0);
    tick(); rst = 1'b0; expect_out("rst_release", E_RUN, 16'd0);
    tick(); bus.id_halt = 1'b1; expect_out("hlt2_t0", E_HLT, 16'd0);
    tick(); idle(); expect_out("drain2_t1", E_DRN, 16'd1);
    tick(); rst = 1'b1; expect_out("rst_drain", E_RUN, 16'd0);
    tick(); rst = 1'b0; expect_out("rst_drain_rel", E_RUN, 16'd0);

    // HLT with a 2-cycle miss inside DRAIN: halted at t+6
    tick(); bus.id_halt = 1'b1; expect_out("hlt3_t0", E_HLT, 16'd0);
    tick(); idle(); expect_out("drain3_t1", E_DRN, 16'd1);
    tick(); bus.dmem_req = 1'b1; expect_out("drain3_miss1", E_DRNM, 16'd2);
    tick(); expect_out("drain3_miss2", E_DRNM, 16'd3);
    tick(); idle(); expect_out("drain3_t4", E_DRN, 16'd4);
    tick(); expect_out("drain3_t5", E_DRN, 16'd5);
    tick(); expect_out("halted3_t6", E_HALTD, 16'd6);

    // Saturation through a miss held for 70000 cycles
    tick(); rst = 1'b1; expect_out("rst_sat", E_RUN, 16'd0);
    tick(); rst = 1'b0; bus.dmem_req = 1'b1; expect_out("sat_start", E_FRZ, 16'd0);
    repeat (70000) @(posedge clk);
    #1; expect_out("sat_held", E_FRZ, 16'hFFFF);
    tick(); bus.dmem_ack = 1'b1; expect_out("sat_ack", E_RUN, 16'hFFFF);
    tick(); idle(); bus.dmem_req = 1'b1; expect_out("sat_remiss", E_FRZ, 16'hFFFF);
    tick(); idle(); expect_out("sat_wait", E_FRZ, 16'hFFFF);

    // Drain the scoreboard with a bounded wait
    repeat (3) @(negedge clk);
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left, required 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
